// File: rtl/checker_pkg.sv
// -----------------------------------------------------------------------------
// checker_pkg
// Shared definitions for the result checker: the run-state enum and the
// default widths used by result_checker and sat_counter.
// -----------------------------------------------------------------------------
package checker_pkg;

    // Default width of the compared data words.
    localparam int W_DEFAULT  = 8;
    // Default width of every counter and index.
    localparam int CW_DEFAULT = 16;

    // Checker run state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : checker_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, forces q to 0
//   clr    in   synchronous clear to 0 (wins over inc)
//   inc    in   add one unless already saturated
//   q      out  current count
// -----------------------------------------------------------------------------
module sat_counter
    import checker_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: assign a default before any branch so always_comb never infers a latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CW{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule : sat_counter

// File: rtl/result_checker.sv
// -----------------------------------------------------------------------------
// result_checker
// Compares a stream of actual/expected word pairs during a run, counting
// accepted items and mismatches and capturing details of the first mismatch.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   start             begin a new run (ignored while a run is in progress)
//   valid             actual/expected/last carry an item this cycle
//   ready             item accepted this cycle (registered, high in RUN)
//   actual, expected  the pair being compared
//   last              final item of the run
//   busy, done, pass  run status; pass = done with zero mismatches
//   err_pulse         one-cycle pulse after a mismatching item is accepted
//   chk_count         items accepted this run (saturating)
//   err_count         mismatches this run (saturating)
//   first_err_idx     chk_count at the first mismatch
//   first_err_act/exp the pair that produced the first mismatch
// -----------------------------------------------------------------------------
module result_checker
    import checker_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          valid,
    output logic          ready,
    input  logic [W-1:0]  actual,
    input  logic [W-1:0]  expected,
    input  logic          last,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          err_pulse,
    output logic [CW-1:0] chk_count,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] first_err_idx,
    output logic [W-1:0]  first_err_act,
    output logic [W-1:0]  first_err_exp
);

    state_e        state_q,         state_d;
    logic          ready_q,         ready_d;
    logic          busy_q,          busy_d;
    logic          done_q,          done_d;
    logic          pass_q,          pass_d;
    logic          err_pulse_q,     err_pulse_d;
    logic [CW-1:0] first_err_idx_q, first_err_idx_d;
    logic [W-1:0]  first_err_act_q, first_err_act_d;
    logic [W-1:0]  first_err_exp_q, first_err_exp_d;

    logic start_run;
    logic accept;
    logic mismatch;
    logic err_zero_d;

    // ready_q is high exactly in RUN, so accepting never looks at valid
    // combinationally on the ready side.
    assign start_run = start && (state_q != RUN);
    assign accept    = valid && ready_q;
    assign mismatch  = accept && (actual != expected);

    sat_counter #(.CW(CW)) u_chk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .inc   (accept),
        .q     (chk_count)
    );

    sat_counter #(.CW(CW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_run),
        .inc   (mismatch),
        .q     (err_count)
    );

    always_comb begin
        state_d         = state_q;
        first_err_idx_d = first_err_idx_q;
        first_err_act_d = first_err_act_q;
        first_err_exp_d = first_err_exp_q;

        unique case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && last) state_d = DONE;
            default:    state_d = IDLE;
        endcase

        if (start_run) begin
            first_err_idx_d = '0;
            first_err_act_d = '0;
            first_err_exp_d = '0;
        end else if (mismatch && (err_count == '0)) begin
            // Only the first mismatch of a run is captured; a saturated
            // err_count never returns to zero, so it cannot re-trigger.
            first_err_idx_d = chk_count;
            first_err_act_d = actual;
            first_err_exp_d = expected;
        end

        // Zero-error status as it will be after this edge, so pass can be
        // registered alongside done.
        if (start_run)     err_zero_d = 1'b1;
        else if (mismatch) err_zero_d = 1'b0;
        else               err_zero_d = (err_count == '0);

        ready_d     = (state_d == RUN);
        busy_d      = (state_d == RUN);
        done_d      = (state_d == DONE);
        pass_d      = (state_d == DONE) && err_zero_d;
        err_pulse_d = mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_pulse_q     <= 1'b0;
            // NOTE: capture registers are reset as well; their value is visible at the ports.
            first_err_idx_q <= '0;
            first_err_act_q <= '0;
            first_err_exp_q <= '0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_pulse_q     <= err_pulse_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_act_q <= first_err_act_d;
            first_err_exp_q <= first_err_exp_d;
        end
    end

    assign ready         = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_pulse     = err_pulse_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_act = first_err_act_q;
    assign first_err_exp = first_err_exp_q;

endmodule : result_checker

// File: tb/tb_result_checker.sv
// -----------------------------------------------------------------------------
// tb_result_checker
// Directed, table-driven bench for result_checker. A default-width instance
// runs the vector table and the reset sequence; a CW=4 instance shares the
// same inputs and is used for the saturation sequence.
// -----------------------------------------------------------------------------
module tb_result_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [7:0]  actual;
    logic [7:0]  expected;
    logic        last;

    logic        ready, busy, done, pass, err_pulse;
    logic [15:0] chk_count, err_count, first_err_idx;
    logic [7:0]  first_err_act, first_err_exp;

    logic        d2_ready, d2_busy, d2_done, d2_pass, d2_err_pulse;
    logic [3:0]  d2_chk_count, d2_err_count, d2_first_err_idx;
    logic [7:0]  d2_first_err_act, d2_first_err_exp;

    int n_cmp = 0;
    int n_bad = 0;

    result_checker #(.W(8), .CW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .valid         (valid),
        .ready         (ready),
        .actual        (actual),
        .expected      (expected),
        .last          (last),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_pulse     (err_pulse),
        .chk_count     (chk_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_act (first_err_act),
        .first_err_exp (first_err_exp)
    );

    result_checker #(.W(8), .CW(4)) dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .valid         (valid),
        .ready         (d2_ready),
        .actual        (actual),
        .expected      (expected),
        .last          (last),
        .busy          (d2_busy),
        .done          (d2_done),
        .pass          (d2_pass),
        .err_pulse     (d2_err_pulse),
        .chk_count     (d2_chk_count),
        .err_count     (d2_err_count),
        .first_err_idx (d2_first_err_idx),
        .first_err_act (d2_first_err_act),
        .first_err_exp (d2_first_err_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  act;
        logic [7:0]  exp;
        logic        last;
        logic        e_busy;
        logic        e_done;
        logic        e_pass;
        logic        e_ep;
        logic [15:0] e_chk;
        logic [15:0] e_err;
        logic [15:0] e_idx;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] a,
                         input logic [7:0] e, input logic l);
        start    = s;
        valid    = v;
        actual   = a;
        expected = e;
        last     = l;
    endtask

    // One rising edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] a,
                                input logic [7:0] e, input logic l,
                                input logic eb, input logic ed, input logic ep,
                                input logic epl, input int ec, input int ee,
                                input int ei);
        vec_t r;
        r.start = s;   r.valid = v;   r.act = a;    r.exp = e;   r.last = l;
        r.e_busy = eb; r.e_done = ed; r.e_pass = ep; r.e_ep = epl;
        r.e_chk = 16'(ec); r.e_err = 16'(ee); r.e_idx = 16'(ei);
        return r;
    endfunction

    initial begin
        //              st  v  act    exp    last  busy done pass ep chk err idx
        // Four matching items, last on the 4th.
        vecs[0]  = mk(1, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'h11, 8'h11, 0,   1, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 1, 8'h22, 8'h22, 0,   1, 0, 0, 0, 2, 0, 0);
        vecs[3]  = mk(0, 1, 8'h33, 8'h33, 0,   1, 0, 0, 0, 3, 0, 0);
        vecs[4]  = mk(0, 1, 8'h44, 8'h44, 1,   0, 1, 1, 0, 4, 0, 0);
        vecs[5]  = mk(0, 0, 8'h00, 8'h00, 0,   0, 1, 1, 0, 4, 0, 0);
        // valid+last mismatch while DONE: ignored.
        vecs[6]  = mk(0, 1, 8'h99, 8'h98, 1,   0, 1, 1, 0, 4, 0, 0);
        // Two mismatches out of three items.
        vecs[7]  = mk(1, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 8'h10, 8'h10, 0,   1, 0, 0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 1, 8'hAB, 8'hAC, 0,   1, 0, 0, 1, 2, 1, 1);
        vecs[10] = mk(0, 1, 8'h05, 8'h06, 1,   0, 1, 0, 1, 3, 2, 1);
        vecs[11] = mk(0, 0, 8'h00, 8'h00, 0,   0, 1, 0, 0, 3, 2, 1);
        // Gapped valid, start pulsed mid-run has no effect; start clears first_err.
        vecs[12] = mk(1, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 8'h01, 8'h01, 0,   1, 0, 0, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 1, 0, 0);
        vecs[15] = mk(1, 1, 8'h02, 8'h02, 0,   1, 0, 0, 0, 2, 0, 0);
        vecs[16] = mk(1, 0, 8'h00, 8'h00, 0,   1, 0, 0, 0, 2, 0, 0);
        vecs[17] = mk(0, 1, 8'h03, 8'h03, 1,   0, 1, 1, 0, 3, 0, 0);

        drive(0, 0, 8'h00, 8'h00, 0);
        rst_n = 1'b0;
        #3;
        check("reset_busy",  32'(busy), 0);
        check("reset_ready", 32'(ready), 0);
        check("reset_done",  32'(done), 0);
        check("reset_pass",  32'(pass), 0);
        check("reset_chk",   32'(chk_count), 0);
        check("reset_err",   32'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].act, vecs[i].exp, vecs[i].last);
            step();
            check($sformatf("v%0d_busy", i),  32'(busy),          32'(vecs[i].e_busy));
            check($sformatf("v%0d_ready", i), 32'(ready),         32'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i),  32'(done),          32'(vecs[i].e_done));
            check($sformatf("v%0d_pass", i),  32'(pass),          32'(vecs[i].e_pass));
            check($sformatf("v%0d_ep", i),    32'(err_pulse),     32'(vecs[i].e_ep));
            check($sformatf("v%0d_chk", i),   32'(chk_count),     32'(vecs[i].e_chk));
            check($sformatf("v%0d_err", i),   32'(err_count),     32'(vecs[i].e_err));
            check($sformatf("v%0d_idx", i),   32'(first_err_idx), 32'(vecs[i].e_idx));
            if (i == 11) begin
                check("first_err_act", 32'(first_err_act), 32'h0000_00AB);
                check("first_err_exp", 32'(first_err_exp), 32'h0000_00AC);
            end
            if (i == 12) begin
                check("clr_first_act", 32'(first_err_act), 0);
                check("clr_first_exp", 32'(first_err_exp), 0);
            end
        end
        drive(0, 0, 8'h00, 8'h00, 0);
        step();

        // Reset mid-run after two items, the second a mismatch.
        drive(1, 0, 8'h00, 8'h00, 0);
        step();
        drive(0, 1, 8'h01, 8'h01, 0);
        step();
        drive(0, 1, 8'hAA, 8'hAB, 0);
        step();
        drive(0, 0, 8'h00, 8'h00, 0);
        check("pre_rst_ep",  32'(err_pulse), 1);
        check("pre_rst_chk", 32'(chk_count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_ready", 32'(ready), 0);
        check("mid_rst_ep",    32'(err_pulse), 0);
        check("mid_rst_chk",   32'(chk_count), 0);
        check("mid_rst_err",   32'(err_count), 0);
        check("mid_rst_idx",   32'(first_err_idx), 0);
        check("mid_rst_act",   32'(first_err_act), 0);
        check("mid_rst_exp",   32'(first_err_exp), 0);
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);
        drive(1, 0, 8'h00, 8'h00, 0);
        step();
        drive(0, 1, 8'h5A, 8'h5A, 1);
        step();
        drive(0, 0, 8'h00, 8'h00, 0);
        check("single_done", 32'(done), 1);
        check("single_pass", 32'(pass), 1);
        check("single_chk",  32'(chk_count), 1);
        check("single_err",  32'(err_count), 0);
        check("single_ready_low", 32'(ready), 0);

        // Saturation: 17 mismatching items into the CW=4 instance.
        drive(1, 0, 8'h00, 8'h00, 0);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 8'(i), ~8'(i), (i == 16) ? 1'b1 : 1'b0);
            step();
        end
        drive(0, 0, 8'h00, 8'h00, 0);
        check("sat_done", 32'(d2_done), 1);
        check("sat_pass", 32'(d2_pass), 0);
        check("sat_err",  32'(d2_err_count), 15);
        check("sat_chk",  32'(d2_chk_count), 15);
        check("sat_idx",  32'(d2_first_err_idx), 0);
        check("sat_act",  32'(d2_first_err_act), 32'h0000_0000);
        check("sat_exp",  32'(d2_first_err_exp), 32'h0000_00FF);
        check("wide_err", 32'(err_count), 17);
        check("wide_chk", 32'(chk_count), 17);
        step();
        check("sat_hold_err", 32'(d2_err_count), 15);
        check("sat_hold_ep",  32'(d2_err_pulse), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_result_checker
